// File: rtl/rv32e_program_mem_pkg.sv
// rv32e_program_mem_pkg: shared constants and types for the program memory and its boot loader.
package rv32e_program_mem_pkg;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   typedef enum logic {PM_ST_LOAD = 1'b0, PM_ST_RUN = 1'b1} pm_state_e;
   typedef logic [1:0] byte_idx_t;
endpackage

// File: rtl/rv32e_word_assembler.sv
// rv32e_word_assembler: packs serial bytes little-endian into 32-bit words, zero-padding on last.
module rv32e_word_assembler
   import rv32e_program_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   input  logic        last_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);
   byte_idx_t   cnt_q, cnt_d;
   logic [23:0] buf_q, buf_d;
   // buf_q is zero above the filled bytes, so merging the new byte also pads a short final word
   always_comb begin
      word_o = {8'h00, buf_q} | ({24'h0, byte_i} << {cnt_q, 3'b000});
      word_valid_o = byte_valid_i && (last_i || cnt_q == 2'd3);
      cnt_d = cnt_q;
      buf_d = buf_q;
      if (clear_i) begin
         cnt_d = '0;
         buf_d = '0;
      end else if (byte_valid_i) begin
         cnt_d = word_valid_o ? '0 : cnt_q + 2'd1;
         buf_d = word_valid_o ? '0 : word_o[23:0];
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
         buf_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         buf_q <= buf_d;
      end
   end
endmodule

// File: rtl/rv32e_program_mem.sv
// rv32e_program_mem: instruction memory with async read port and a byte-serial boot loader
// that holds the CPU in reset until an image has been loaded.
module rv32e_program_mem
   import rv32e_program_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 8,
   parameter bit BOOT_LOAD   = 1'b1,
   parameter     INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_program_addr_bus,
   output logic [31:0] mem_program_data_bus,
   input  logic        load_start,
   input  logic        load_valid,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   output logic        load_ready,
   output logic        load_error,
   output logic        cpu_reset_n
);
   localparam pm_state_e RESET_ST = BOOT_LOAD ? PM_ST_LOAD : PM_ST_RUN;
   logic [31:0]     mem_q [DEPTH_WORDS];
   pm_state_e       state_q, state_d;
   logic [ADDR_W:0] waddr_q, waddr_d;
   logic            err_q, err_d;
   logic            xfer, restart, overflow, word_valid;
   logic [31:0]     word;
   logic            unused_addr_bits;
   assign unused_addr_bits = ^mem_program_addr_bus[1:0];
   assign mem_program_data_bus = |mem_program_addr_bus[31:ADDR_W+2] ? INST_NOP
                                 : mem_q[mem_program_addr_bus[ADDR_W+1:2]];
   assign load_ready  = state_q == PM_ST_LOAD;
   assign cpu_reset_n = state_q == PM_ST_RUN;
   assign load_error  = err_q;
   assign xfer        = load_valid && load_ready;
   assign restart     = load_start && state_q == PM_ST_RUN;
   // the extra waddr bit marks a full array; it saturates there so overflow stays visible
   assign overflow    = waddr_q[ADDR_W];
   rv32e_word_assembler u_asm (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (restart),
      .byte_valid_i (xfer),
      .byte_i       (load_byte),
      .last_i       (load_last),
      .word_valid_o (word_valid),
      .word_o       (word)
   );
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      err_d   = err_q;
      if (restart) begin
         state_d = PM_ST_LOAD;
         waddr_d = '0;
         err_d   = 1'b0;
      end else if (xfer) begin
         err_d   = err_q || overflow;
         waddr_d = (word_valid && !overflow) ? waddr_q + (ADDR_W+1)'(1) : waddr_q;
         state_d = load_last ? PM_ST_RUN : state_q;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RESET_ST;
         waddr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (reset && xfer && word_valid && !overflow) mem_q[waddr_q[ADDR_W-1:0]] <= word;
   end
endmodule
